// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one registered unsigned magnitude comparator among NREQ requesters.
// Latency: req sampled in IDLE -> gnt next cycle -> done + flags the cycle after; 3 cycles per compare.
// Backpressure: level requests stay pending until granted; req changes while busy are ignored until IDLE.
module cmp_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] in1_all,
    input  logic [NREQ*WIDTH-1:0] in2_all,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  lower,
    output logic                  equal,
    output logic                  greater,
    output logic                  busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);
    localparam logic [IW-1:0]   LAST = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    rr;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    win;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] sel1;
    logic [WIDTH-1:0] sel2;

    // Winner is the set request with the smallest wrapped distance from rr.
    function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
        logic [IW:0]   best_d;
        logic [IW-1:0] best;
        logic [IW:0]   d;
        best_d = '1;
        best   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) >= p)
                d = {1'b0, IW'(i)} - {1'b0, p};
            else
                d = {1'b0, IW'(i)} + (IW+1)'(NREQ) - {1'b0, p};
            if (r[i] && (d < best_d)) begin
                best_d = d;
                best   = IW'(i);
            end
        end
        return best;
    endfunction

    always_comb begin
        win  = pick(req, rr);
        sel1 = '0;
        sel2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                sel1 = in1_all[i*WIDTH +: WIDTH];
                sel2 = in2_all[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr      <= '0;
            owner   <= '0;
            op1     <= '0;
            op2     <= '0;
            gnt     <= '0;
            done    <= '0;
            lower   <= 1'b0;
            equal   <= 1'b0;
            greater <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (req != '0) begin
                        owner <= win;
                        op1   <= sel1;
                        op2   <= sel2;
                        gnt   <= ONE << win;
                        busy  <= 1'b1;
                        state <= CMP;
                    end else begin
                        gnt <= '0;
                    end
                end
                CMP: begin
                    gnt     <= '0;
                    lower   <= (op1 <  op2);
                    equal   <= (op1 == op2);
                    greater <= (op1 >  op2);
                    done    <= ONE << owner;
                    state   <= DONE;
                end
                DONE: begin
                    done  <= '0;
                    busy  <= 1'b0;
                    rr    <= (owner == LAST) ? '0 : owner + IW'(1);
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed bench for cmp_share_arbiter: vector table, reset mid-compare, contention, exhaustive 4-bit pairs.
module tb_cmp_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] in1_all;
    logic [15:0] in2_all;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        lower;
    logic        equal;
    logic        greater;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [2:0] prev_flags;

    localparam logic [2:0] FL = 3'b100;
    localparam logic [2:0] FE = 3'b010;
    localparam logic [2:0] FG = 3'b001;

    cmp_share_arbiter #(.WIDTH(4), .NREQ(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .in1_all (in1_all),
        .in2_all (in2_all),
        .gnt     (gnt),
        .done    (done),
        .lower   (lower),
        .equal   (equal),
        .greater (greater),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic [3:0] o1;
        logic [3:0] o2;
        int         own;
        logic [2:0] ef;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one request from IDLE and check the gnt, done and idle cycles that follow.
    task automatic run_txn(input logic [3:0] r, input logic [15:0] a1, input logic [15:0] a2,
                           input int own, input logic [2:0] ef);
        req     = r;
        in1_all = a1;
        in2_all = a2;
        @(negedge clk);
        chk("gnt", {28'd0, gnt}, 32'd1 << own);
        chk("busy_cmp", {31'd0, busy}, 32'd1);
        chk("done_early", {28'd0, done}, 32'd0);
        chk("flags_hold_gnt", {29'd0, lower, equal, greater}, {29'd0, prev_flags});
        in1_all = ~a1;
        in2_all = ~a2;
        @(negedge clk);
        chk("done", {28'd0, done}, 32'd1 << own);
        chk("flags", {29'd0, lower, equal, greater}, {29'd0, ef});
        chk("busy_done", {31'd0, busy}, 32'd1);
        req = 4'b0000;
        prev_flags = ef;
        @(negedge clk);
        chk("idle_quiet", {23'd0, busy, done, gnt}, 32'd0);
        chk("flags_hold_idle", {29'd0, lower, equal, greater}, {29'd0, ef});
    endtask

    function automatic logic [15:0] place(input int own, input logic [3:0] mine, input logic [3:0] other);
        logic [15:0] v;
        v = '0;
        for (int s = 0; s < 4; s++)
            v = v | (16'((s == own) ? mine : other) << (4 * s));
        return v;
    endfunction

    initial begin
        logic [2:0] cexp[4];
        logic [15:0] a1;
        logic [15:0] a2;
        int nd;
        int ng;

        // rr history: 0 ->1 ->3 ->3 ->1 ->2 ->0 ->1 ->0 ->2
        tbl[0] = '{4'b0001, 4'd5,  4'd1,  0, FG};
        tbl[1] = '{4'b0100, 4'd9,  4'd9,  2, FE};
        tbl[2] = '{4'b0100, 4'd3,  4'd12, 2, FL};
        tbl[3] = '{4'b0011, 4'd0,  4'd0,  0, FE};
        tbl[4] = '{4'b0011, 4'd15, 4'd15, 1, FE};
        tbl[5] = '{4'b1001, 4'd0,  4'd15, 3, FL};
        tbl[6] = '{4'b1001, 4'd15, 4'd0,  0, FG};
        tbl[7] = '{4'b1000, 4'd7,  4'd8,  3, FL};
        tbl[8] = '{4'b1110, 4'd8,  4'd7,  1, FG};
        tbl[9] = '{4'b0110, 4'd6,  4'd2,  2, FG};

        rst_n = 1'b0;
        req = '0;
        in1_all = '0;
        in2_all = '0;
        prev_flags = 3'b000;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {22'd0, gnt, done, lower, equal, greater, busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {23'd0, busy, done, gnt}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            // Non-winning slots carry swapped operands so a wrong slice flips the result.
            a1 = place(tbl[i].own, tbl[i].o1, tbl[i].o2);
            a2 = place(tbl[i].own, tbl[i].o2, tbl[i].o1);
            run_txn(tbl[i].r, a1, a2, tbl[i].own, tbl[i].ef);
        end

        // Reset while in CMP: everything clears at once, no done afterwards.
        req = 4'b0010;
        in1_all = place(1, 4'd4, 4'd0);
        in2_all = place(1, 4'd2, 4'd0);
        @(negedge clk);
        chk("rst_pre_gnt", {28'd0, gnt}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {22'd0, gnt, done, lower, equal, greater, busy}, 32'd0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        prev_flags = 3'b000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_no_done", {27'd0, busy, done}, 32'd0);
        end

        // Contention from rr=0: slot0 1<6, slot1 9=9, slot2 7>3, slot3 2=2.
        cexp[0] = FL;
        cexp[1] = FE;
        cexp[2] = FG;
        cexp[3] = FE;
        in1_all = {4'd2, 4'd7, 4'd9, 4'd1};
        in2_all = {4'd2, 4'd3, 4'd9, 4'd6};
        req = 4'b1111;
        nd = 0;
        ng = 0;
        for (int c = 1; c <= 20 && nd < 4; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                chk("cont_gnt", {28'd0, gnt}, 32'd1 << ng);
                chk("cont_gnt_cycle", c, 1 + 3 * ng);
                ng++;
            end
            if (done != '0) begin
                chk("cont_done", {28'd0, done}, 32'd1 << nd);
                chk("cont_done_cycle", c, 2 + 3 * nd);
                chk("cont_flags", {29'd0, lower, equal, greater}, {29'd0, cexp[nd]});
                req = req & ~done;
                nd++;
            end
        end
        chk("cont_served", nd, 4);
        req = '0;
        @(negedge clk);
        prev_flags = FE;

        // Exhaustive 4-bit pairs through requester 2.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [2:0] ef;
                ef = (a < b) ? FL : ((a == b) ? FE : FG);
                run_txn(4'b0100, place(2, 4'(a), 4'(b)), place(2, 4'(b), 4'(a)), 2, ef);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
